// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: status codes, instruction codes, register ids,
// and the writeback status FSM encoding.
package y86_pkg;

  // Processor status codes
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Instruction codes referenced by writeback
  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;

  // Register ids
  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  // Writeback status FSM: leaves RUN on an exceptional retire, returns only on reset
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  // Undefined status codes 5..7 are reported as an invalid instruction
  function automatic logic [2:0] norm_stat(input logic [2:0] s);
    return (s > SINS) ? SINS : s;
  endfunction

endpackage

// File: rtl/regfile_15x64.sv
// Architectural register storage: two write ports (M wins on a shared
// destination), two combinational read ports, synchronous active-low clear.
// Reads return the pre-write value in the cycle of a write (no bypass).
module regfile_15x64
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we_e,
  input  logic [3:0]        i_dst_e,
  input  logic [DATA_W-1:0] i_val_e,
  input  logic              i_we_m,
  input  logic [3:0]        i_dst_m,
  input  logic [DATA_W-1:0] i_val_m,
  input  logic [3:0]        i_src_a,
  input  logic [3:0]        i_src_b,
  output logic [DATA_W-1:0] o_rval_a,
  output logic [DATA_W-1:0] o_rval_b
);

  localparam logic [3:0] LAST_ID = 4'(NREG - 1);

  logic [DATA_W-1:0] r_regs [NREG];

  // Clear on reset; otherwise apply E then M so M takes priority on the same id
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (i_we_e && (i_dst_e <= LAST_ID)) r_regs[i_dst_e] <= i_val_e;
      if (i_we_m && (i_dst_m <= LAST_ID)) r_regs[i_dst_m] <= i_val_m;
    end
  end

  // Asynchronous read ports; ids past the array (RNONE) read as zero
  always_comb begin
    o_rval_a = '0;
    o_rval_b = '0;
    if (i_src_a <= LAST_ID) o_rval_a = r_regs[i_src_a];
    if (i_src_b <= LAST_ID) o_rval_b = r_regs[i_src_b];
  end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: commit gating into the register file, sticky
// processor status FSM, and the retired-instruction counter.
// There is no handshake: W presents one instruction per cycle, and W_stall
// holds it (no state change) until the stall drops.
module wb_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        W_stat,
  input  logic [3:0]        W_icode,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic              W_stall,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [2:0]        Stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  wb_state_e        r_state;
  wb_state_e        w_state_next;
  logic [2:0]       r_stat;
  logic [2:0]       w_stat_next;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] w_retired_next;
  logic             w_live;
  logic             w_commit;
  logic             w_exc;
  logic             w_we_e;
  logic             w_we_m;

  // Status register, FSM state and counter; reset overrides any same-cycle commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_stat    <= SAOK;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_stat    <= w_stat_next;
      r_retired <= w_retired_next;
    end
  end

  // Commit gating, next status and next count
  always_comb begin
    w_live         = !W_stall && (r_state == ST_RUN);
    w_commit       = w_live && (W_stat == SAOK);
    w_exc          = w_live && (W_stat >= SHLT);
    w_state_next   = r_state;
    w_stat_next    = r_stat;
    w_retired_next = r_retired;
    w_we_e         = w_commit && (W_dstE != RNONE);
    w_we_m         = w_commit && (W_dstM != RNONE);
    if (w_exc) begin
      w_state_next = ST_HALTED;
      w_stat_next  = norm_stat(W_stat);
    end else if (w_live) begin
      // Bubbles and normal instructions both report AOK
      w_stat_next = SAOK;
    end
    if (w_commit && (W_icode != INOP)) w_retired_next = r_retired + CNT_W'(1);
  end

  regfile_15x64 #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we_e   (w_we_e),
    .i_dst_e  (W_dstE),
    .i_val_e  (W_valE),
    .i_we_m   (w_we_m),
    .i_dst_m  (W_dstM),
    .i_val_m  (W_valM),
    .i_src_a  (d_srcA),
    .i_src_b  (d_srcB),
    .o_rval_a (d_rvalA),
    .o_rval_b (d_rvalB)
  );

  assign Stat    = r_stat;
  assign halted  = (r_state == ST_HALTED);
  assign retired = r_retired;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile (built with a 4-bit retired counter so wrap is reachable).
// Drivers set inputs #1 after posedge and push expected values; a monitor
// compares them against the DUT outputs on the following negedge.
module tb_wb_regfile;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  // Observation selectors
  localparam int SEL_A   = 0;
  localparam int SEL_B   = 1;
  localparam int SEL_ST  = 2;
  localparam int SEL_HLT = 3;
  localparam int SEL_RET = 4;

  logic              clk;
  logic              rst_n;
  logic [2:0]        W_stat;
  logic [3:0]        W_icode;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;
  logic              W_stall;
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;
  logic [DATA_W-1:0] d_rvalA;
  logic [DATA_W-1:0] d_rvalB;
  logic [2:0]        Stat;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  logic [63:0] exp_q[$];
  int          sel_q[$];
  string       tag_q[$];
  int          n_checks;
  int          n_pass;

  wb_regfile #(
    .DATA_W (DATA_W),
    .NREG   (15),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .W_stat  (W_stat),
    .W_icode (W_icode),
    .W_valE  (W_valE),
    .W_valM  (W_valM),
    .W_dstE  (W_dstE),
    .W_dstM  (W_dstM),
    .W_stall (W_stall),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .d_rvalA (d_rvalA),
    .d_rvalB (d_rvalB),
    .Stat    (Stat),
    .halted  (halted),
    .retired (retired)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic stall);
    W_stat  = st;
    W_icode = ic;
    W_dstE  = de;
    W_valE  = ve;
    W_dstM  = dm;
    W_valM  = vm;
    W_stall = stall;
  endtask

  task automatic bubble();
    issue(3'd0, 4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
  endtask

  task automatic expect_val(input int sel, input logic [63:0] v, input string tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Monitor / scoreboard: drain all expectations issued this cycle
  initial begin
    logic [63:0] act;
    logic [63:0] expv;
    int          sel;
    string       tag;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        sel  = sel_q.pop_front();
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        case (sel)
          SEL_A:   act = d_rvalA;
          SEL_B:   act = d_rvalB;
          SEL_ST:  act = {61'd0, Stat};
          SEL_HLT: act = {63'd0, halted};
          default: act = {60'd0, retired};
        endcase
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
      end
    end
  end

  // Directed stimulus
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    d_srcA   = 4'hF;
    d_srcB   = 4'hF;
    bubble();
    step();
    step();
    rst_n = 1'b1;

    // Reset state: every id (and RNONE) reads zero
    for (int id = 0; id < 16; id++) begin
      d_srcA = 4'(id);
      d_srcB = 4'(15 - id);
      expect_val(SEL_A, 64'd0, "rst_rvalA");
      expect_val(SEL_B, 64'd0, "rst_rvalB");
      step();
    end
    expect_val(SEL_ST, 64'd1, "rst_stat");
    expect_val(SEL_HLT, 64'd0, "rst_halted");
    expect_val(SEL_RET, 64'd0, "rst_retired");
    step();

    // Simple commit; same-cycle read sees the old value
    issue(3'd1, 4'h2, 4'd3, 64'hDEAD, 4'hF, 64'd0, 1'b0);
    d_srcA = 4'd3;
    expect_val(SEL_A, 64'd0, "same_cycle_old");
    step();
    bubble();
    expect_val(SEL_A, 64'hDEAD, "commit_reg3");
    expect_val(SEL_RET, 64'd1, "commit_retired");
    step();

    // popq %rsp: valM wins on a shared destination
    issue(3'd1, 4'hB, 4'd4, 64'h100, 4'd4, 64'h55, 1'b0);
    step();
    bubble();
    d_srcB = 4'd4;
    expect_val(SEL_B, 64'h55, "popq_rsp");
    expect_val(SEL_RET, 64'd2, "popq_retired");
    step();

    // Stall holds everything, then commits once released
    issue(3'd1, 4'h2, 4'd5, 64'd7, 4'hF, 64'd0, 1'b1);
    d_srcA = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val(SEL_A, 64'd0, "stall_reg5");
      expect_val(SEL_RET, 64'd2, "stall_retired");
    end
    W_stall = 1'b0;
    step();
    bubble();
    expect_val(SEL_A, 64'd7, "unstall_reg5");
    expect_val(SEL_RET, 64'd3, "unstall_retired");
    step();

    // Committed nop does not count
    issue(3'd1, 4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    step();
    bubble();
    expect_val(SEL_RET, 64'd3, "nop_not_counted");

    // Bubbles keep AOK and do not count
    for (int i = 0; i < 4; i++) begin
      step();
      expect_val(SEL_ST, 64'd1, "bubble_stat");
      expect_val(SEL_RET, 64'd3, "bubble_retired");
    end

    // Address error: no write, sticky halt, later commits ignored
    issue(3'd3, 4'h5, 4'd6, 64'd9, 4'hF, 64'd0, 1'b0);
    d_srcA = 4'd6;
    step();
    issue(3'd1, 4'h2, 4'd6, 64'h11, 4'hF, 64'd0, 1'b0);
    expect_val(SEL_A, 64'd0, "sadr_reg6");
    expect_val(SEL_ST, 64'd3, "sadr_stat");
    expect_val(SEL_HLT, 64'd1, "sadr_halted");
    step();
    step();
    expect_val(SEL_A, 64'd0, "halted_reg6");
    expect_val(SEL_ST, 64'd3, "halted_stat");
    expect_val(SEL_RET, 64'd3, "halted_retired");
    // Reset while a commit is presented: reset wins
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bubble();
    d_srcA = 4'd3;
    d_srcB = 4'd6;
    expect_val(SEL_ST, 64'd1, "rerst_stat");
    expect_val(SEL_HLT, 64'd0, "rerst_halted");
    expect_val(SEL_A, 64'd0, "rerst_reg3");
    expect_val(SEL_B, 64'd0, "rerst_reg6");
    expect_val(SEL_RET, 64'd0, "rerst_retired");
    step();

    // Counter wrap in the 4-bit build: 15 commits then one more
    issue(3'd1, 4'h3, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    bubble();
    expect_val(SEL_RET, 64'd15, "retired_max");
    step();
    issue(3'd1, 4'h3, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0);
    step();
    bubble();
    expect_val(SEL_RET, 64'd0, "retired_wrap");
    step();

    // Undefined status 6 reports SINS and halts
    issue(3'd6, 4'h2, 4'd2, 64'd5, 4'hF, 64'd0, 1'b0);
    step();
    bubble();
    expect_val(SEL_ST, 64'd4, "undef_stat_sins");
    expect_val(SEL_HLT, 64'd1, "undef_halted");
    step();
    step();

    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      n_checks += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
